inst_mem_boot: RTL



---
 rtl/inst_mem_boot.sv | 102 ++++++++++
 1 files changed

// File: rtl/inst_mem_boot.sv
// Bootloadable instruction memory: valid/ready load port fills words from address 0, then 1-cycle registered fetch.
// load_ready is a pure state decode (no path from load_valid); fetch never stalls and accepts a request every cycle.
module inst_mem_boot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_count,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wptr, wptr_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              done_nxt;
    logic              mem_we;
    logic              fetch_ok;
    logic              addr_bad;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            wptr      <= '0;
            cnt       <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wptr      <= wptr_nxt;
            cnt       <= cnt_nxt;
            load_done <= done_nxt;
        end
    end

    // A restart always wins over a handshake in the same cycle, so its word is dropped.
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        mem_we    = 1'b0;
        if (load_start) begin
            state_nxt = LOAD;
            wptr_nxt  = '0;
            cnt_nxt   = (load_count > DEPTH_CNT) ? DEPTH_CNT : load_count;
        end else if (state == LOAD) begin
            if (cnt == '0) begin
                state_nxt = RUN;
                done_nxt  = 1'b1;
            end else if (load_valid) begin
                mem_we   = 1'b1;
                wptr_nxt = wptr + 1'b1;
                if ({1'b0, wptr} == cnt - 1'b1) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD);

    // Array is deliberately left out of reset so a reset does not wipe the program.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= load_data;
        end
    end

    assign fetch_ok = fetch_en && (state == RUN);
    assign addr_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            inst_valid <= fetch_ok;
            fetch_err  <= fetch_ok && addr_bad;
            if (fetch_ok) begin
                inst <= addr_bad ? '0 : mem[fetch_addr[ADDR_W+1:2]];
            end
        end
    end
endmodule
